coffee_brew_sequencer: RTL
==========================

# coffee_brew_sequencer

Avalon-MM slave controller that sequences one coffee brew cycle: grinder, then heater, then pump, each for a programmable number of clock cycles. A brew starts on a debounced rising edge of the front-panel "preparar" button or on a NIOS write to CTRL. The block sits beside the NIOS PIO peripherals on the system interconnect and drives the actuator enables directly. The NIOS gets status readback and a sticky done interrupt.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new button level
- T_GRIND_RST, 1000: reset value of T_GRIND register
- T_HEAT_RST, 2000: reset value of T_HEAT register
- T_PUMP_RST, 3000: reset value of T_PUMP register
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- address  in  3  register word address
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- preparar_in  in  1  raw button level, asynchronous, active-high
- grinder_en  out  1  grinder actuator enable
- heater_en  out  1  heater actuator enable
- pump_en  out  1  pump actuator enable
- busy  out  1  high in any state other than IDLE
- irq  out  1  done & irq_en

## Operation
Register map. Unmapped addresses read 0 and ignore writes.
- 0 STATUS (RO): bit0 busy; bits3:1 state code (IDLE=0, GRIND=1, HEAT=2, PUMP=3, DONE=4); bit4 done.
- 1 CTRL: bit0 start (W1, self-clearing); bit1 abort (W1, self-clearing); bit2 irq_en (R/W, reset 0); bit3 done_clr (W1).
- 2 T_GRIND, 3 T_HEAT, 4 T_PUMP (R/W, 32 bit): state durations in cycles.

FSM:
- IDLE → GRIND on start (CTRL.start write or debounced button rising edge). Ignored in other states.
- GRIND → HEAT → PUMP → DONE: each timed state lasts max(N,1) cycles. N is the duration register sampled on state entry. Writes to a duration register while busy take effect at the next entry.
- DONE lasts exactly 1 cycle, sets the sticky done flag, then returns to IDLE.
- Abort write in any state: go to IDLE next cycle. Enables drop, done is not set.
- Abort and start in the same write: abort wins.
- done_clr and done-set in the same cycle: set wins.

Outputs:
- Enables are one-hot and registered: grinder_en = state GRIND, heater_en = HEAT, pump_en = PUMP.

Button path:
- preparar_in passes through a 2-FF synchronizer, then a debounce counter.
- The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from the current debounced level.
- A rising edge of the debounced level generates a 1-cycle start pulse.

Counter rules:
- Cycle counter is 32 bit and loads N-1 (0 when N=0).
- The state advances when the counter equals 0; there is no wrap.

## Timing
- Reset values:
  - all outputs 0; readdata 0; state IDLE; done 0; irq_en 0
  - duration registers take their *_RST values
  - debounced level 0; debounce counter 0
- Read latency is 1 cycle: readdata is updated every clk from address, regardless of any read strobe.
- CTRL.start write at edge t: state GRIND and grinder_en=1 after edge t+1. STATUS reflects this on a read issued at t+1.
- Handover between actuators is gap-free with no overlap: grinder_en falls on the same edge heater_en rises.
- Button latency: a clean rising edge of preparar_in yields a start pulse 2 + DEBOUNCE_CYCLES cycles later (±1 cycle for synchronizer sampling).
- irq follows done and irq_en with 1 register stage.
- Reset asserted mid-brew: all enables drop immediately (asynchronous clear).

## Structure
- Shared package coffee_pkg holds:
  - the state enum and its codes
  - register address constants
  - CTRL/STATUS bit index constants
- One sub-module, input_debouncer (synchronizer + debounce counter + rise pulse), parameterized by DEBOUNCE_CYCLES. It is reused for future panel buttons.

## Test plan
- Reset: after reset release, read addresses 0..4 → STATUS=0, T_GRIND=1000, T_HEAT=2000, T_PUMP=3000; all enables 0.
- Write T_GRIND=3, T_HEAT=2, T_PUMP=4, then CTRL=0x5 (start + irq_en) → grinder_en 3 cycles, heater_en 2 cycles, pump_en 4 cycles, DONE 1 cycle; then STATUS=0x10 and irq=1. Write CTRL=0x8 → done=0 and irq=0.
- With DEBOUNCE_CYCLES=8: a button pulse of 5 cycles → no start; a pulse held 20 cycles → exactly one brew; bouncing toggles during the brew → ignored.
- Write abort during HEAT → next cycle IDLE, all enables 0, done stays 0. A start issued afterwards runs a full cycle.
- T_HEAT=0 → HEAT lasts 1 cycle. Start written while busy → no restart and no change in sequence timing.
- Assert reset during PUMP → pump_en drops without a clock edge; registers return to reset values.

Source files
------------

// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee brew sequencer.
// No logic; state codes are the values software reads in STATUS.
// Nothing here applies backpressure.
package coffee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRIND = 3'd1,
    ST_HEAT  = 3'd2,
    ST_PUMP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_T_GRIND = 3'd2;
  localparam logic [2:0] ADDR_T_HEAT  = 3'd3;
  localparam logic [2:0] ADDR_T_PUMP  = 3'd4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_DONE_CLR = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_STATE_LSB = 1;
  localparam int STAT_DONE      = 4;

  // A duration of N cycles loads N-1; zero is treated like one cycle.
  function automatic logic [31:0] dur_load(input logic [31:0] n);
    return (n == 32'd0) ? 32'd0 : n - 32'd1;
  endfunction

endpackage

// File: rtl/coffee_brew_sequencer_input_debouncer.sv
// Button conditioner: 2-FF synchronizer, debounce counter, rising-edge pulse.
// Latency: 2 + DEBOUNCE_CYCLES cycles from a clean input edge to the rise pulse.
// No backpressure; rise is a single-cycle pulse.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button level into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after an unbroken run of differing samples; pulse on 0->1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_b != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_b;
          cnt   <= '0;
          rise  <= sync_b;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coffee_brew_sequencer.sv
// Avalon-MM brew sequencer: grinder -> heater -> pump with programmable durations.
// Latency: CTRL/button start reaches the actuators one cycle after capture; readdata 1 cycle.
// No backpressure: writes always accepted, starts while busy are dropped.
module coffee_brew_sequencer
  import coffee_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int unsigned T_GRIND_RST     = 1000,
  parameter int unsigned T_HEAT_RST      = 2000,
  parameter int unsigned T_PUMP_RST      = 3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        preparar_in,
  output logic        grinder_en,
  output logic        heater_en,
  output logic        pump_en,
  output logic        busy,
  output logic        irq
);

  state_e      state_q;
  state_e      next_state;
  logic [31:0] cnt;
  logic [31:0] t_grind;
  logic [31:0] t_heat;
  logic [31:0] t_pump;
  logic        irq_en;
  logic        done;
  logic        start_req;
  logic        abort_req;
  logic        btn_rise;
  logic        wr_ctrl;
  logic        done_set;
  logic [31:0] status_word;

  assign wr_ctrl  = write && (address == ADDR_CTRL);
  assign done_set = (state_q == ST_DONE) && !abort_req;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .din   (preparar_in),
    .rise  (btn_rise)
  );

  // Capture start/abort commands as one-cycle requests for the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_req <= 1'b0;
      abort_req <= 1'b0;
    end else begin
      start_req <= (wr_ctrl && writedata[CTRL_START]) || btn_rise;
      abort_req <= wr_ctrl && writedata[CTRL_ABORT];
    end
  end

  // Software-writable configuration: durations and interrupt enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_grind <= 32'(T_GRIND_RST);
      t_heat  <= 32'(T_HEAT_RST);
      t_pump  <= 32'(T_PUMP_RST);
      irq_en  <= 1'b0;
    end else if (write) begin
      case (address)
        ADDR_CTRL:    irq_en  <= writedata[CTRL_IRQ_EN];
        ADDR_T_GRIND: t_grind <= writedata;
        ADDR_T_HEAT:  t_heat  <= writedata;
        ADDR_T_PUMP:  t_pump  <= writedata;
        default:      ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= next_state;
  end

  // Next-state: abort overrides everything, timed states advance when the counter hits 0.
  always_comb begin
    next_state = state_q;
    if (abort_req) begin
      next_state = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_req)     next_state = ST_GRIND;
        ST_GRIND: if (cnt == 32'd0)  next_state = ST_HEAT;
        ST_HEAT:  if (cnt == 32'd0)  next_state = ST_PUMP;
        ST_PUMP:  if (cnt == 32'd0)  next_state = ST_DONE;
        ST_DONE:                     next_state = ST_IDLE;
        default:                     next_state = ST_IDLE;
      endcase
    end
  end

  // Duration counter: load on entry to a timed state, count down to 0 without wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 32'd0;
    end else if (next_state != state_q) begin
      case (next_state)
        ST_GRIND: cnt <= dur_load(t_grind);
        ST_HEAT:  cnt <= dur_load(t_heat);
        ST_PUMP:  cnt <= dur_load(t_pump);
        default:  cnt <= 32'd0;
      endcase
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  // Registered one-hot actuator enables and busy, aligned with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grinder_en <= 1'b0;
      heater_en  <= 1'b0;
      pump_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      grinder_en <= (next_state == ST_GRIND);
      heater_en  <= (next_state == ST_HEAT);
      pump_en    <= (next_state == ST_PUMP);
      busy       <= (next_state != ST_IDLE);
    end
  end

  // Sticky done flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else if (done_set) begin
      done <= 1'b1;
    end else if (wr_ctrl && writedata[CTRL_DONE_CLR]) begin
      done <= 1'b0;
    end
  end

  // Interrupt is one register stage behind done and irq_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= done && irq_en;
  end

  // Assemble the STATUS word.
  always_comb begin
    status_word                          = 32'd0;
    status_word[STAT_BUSY]               = busy;
    status_word[STAT_STATE_LSB +: 3]     = state_q;
    status_word[STAT_DONE]               = done;
  end

  // Read mux, updated every cycle from address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        ADDR_STATUS:  readdata <= status_word;
        ADDR_CTRL:    readdata <= {28'd0, 1'b0, irq_en, 2'b00};
        ADDR_T_GRIND: readdata <= t_grind;
        ADDR_T_HEAT:  readdata <= t_heat;
        ADDR_T_PUMP:  readdata <= t_pump;
        default:      readdata <= 32'd0;
      endcase
    end
  end

endmodule
